// File: rtl/winograd_resolver_if.sv
// Signals between the winograd array feeder and the resolver: operand tile,
// the array's redundant output pair, and the resolved dot-product result.
interface winograd_resolver_if #(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int ARRAY_SIZE = 8,
    parameter int NUM_TILES  = 4
);
    localparam int IN_MUL   = ((IN_SIZE_0 > IN_SIZE_1) ? IN_SIZE_0 : IN_SIZE_1) + 1;
    localparam int PP       = ((IN_MUL + 2) / 3) * ARRAY_SIZE;
    localparam int OUT_SIZE = 2 * IN_MUL + ($clog2(PP) - 1) * 2;
    localparam int RES_SIZE = IN_SIZE_0 + IN_SIZE_1 + $clog2(ARRAY_SIZE * NUM_TILES);

    logic                                 in_valid_i;
    logic                                 in_ready_o;
    logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] in_0_i;
    logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] in_1_i;
    logic [1:0][OUT_SIZE-1:0]             arr_out_i;
    logic                                 res_valid_o;
    logic                                 res_ready_i;
    logic [RES_SIZE-1:0]                  res_o;
    logic                                 busy_o;

    modport master (
        output in_valid_i, in_0_i, in_1_i, arr_out_i, res_ready_i,
        input  in_ready_o, res_valid_o, res_o, busy_o
    );

    modport slave (
        input  in_valid_i, in_0_i, in_1_i, arr_out_i, res_ready_i,
        output in_ready_o, res_valid_o, res_o, busy_o
    );
endinterface

// File: rtl/winograd_resolver.sv
// Strips the Winograd correction terms from the array's redundant output and
// accumulates NUM_TILES tiles into one exact signed dot product.
module winograd_resolver #(
    parameter int IN_SIZE_0     = 4,
    parameter int IN_SIZE_1     = 8,
    parameter int ARRAY_SIZE    = 8,
    parameter int NUM_TILES     = 4,
    parameter int ARRAY_LATENCY = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    winograd_resolver_if.slave  bus
);
    localparam int IN_MUL    = ((IN_SIZE_0 > IN_SIZE_1) ? IN_SIZE_0 : IN_SIZE_1) + 1;
    localparam int PP        = ((IN_MUL + 2) / 3) * ARRAY_SIZE;
    localparam int OUT_SIZE  = 2 * IN_MUL + ($clog2(PP) - 1) * 2;
    localparam int RES_SIZE  = IN_SIZE_0 + IN_SIZE_1 + $clog2(ARRAY_SIZE * NUM_TILES);
    localparam int NUM_PAIRS = ARRAY_SIZE / 2;
    localparam int TCNT_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    if (RES_SIZE > OUT_SIZE + 1) begin : g_bad_res_size
        $error("winograd_resolver: RES_SIZE exceeds OUT_SIZE+1");
    end
    if ((ARRAY_SIZE % 2) != 0) begin : g_bad_array_size
        $error("winograd_resolver: ARRAY_SIZE must be even");
    end
    if (NUM_TILES < 1) begin : g_bad_num_tiles
        $error("winograd_resolver: NUM_TILES must be at least 1");
    end
    if (ARRAY_LATENCY < 1) begin : g_bad_latency
        $error("winograd_resolver: ARRAY_LATENCY must be at least 1");
    end

    typedef logic signed [2*IN_SIZE_0-1:0] prod_a_t;
    typedef logic signed [2*IN_SIZE_1-1:0] prod_b_t;

    logic [TCNT_W-1:0]        tcnt_reg;
    logic [RES_SIZE-1:0]      acc_reg;
    logic [RES_SIZE-1:0]      res_reg;
    logic                     res_valid_reg;
    logic [ARRAY_LATENCY-1:0] dl_valid_reg;
    logic [ARRAY_LATENCY-1:0] dl_final_reg;
    logic [RES_SIZE-1:0]      dl_corr_reg [ARRAY_LATENCY];

    logic [RES_SIZE-1:0]      pair_corr [NUM_PAIRS];
    logic [RES_SIZE-1:0]      corr_sum;
    logic [RES_SIZE-1:0]      term;
    logic [RES_SIZE-1:0]      acc_next;
    logic                     tcnt_last;
    logic                     final_in_flight;
    logic                     in_ready;
    logic                     accept;
    logic                     aligned_valid;
    logic                     aligned_final;
    logic                     arr_unused;

    // Per-pair correction a[2j]*a[2j+1] + b[2j]*b[2j+1], exact then wrapped to RES_SIZE.
    for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
        prod_a_t a_lo, a_hi, prod_a;
        prod_b_t b_lo, b_hi, prod_b;
        assign a_lo   = prod_a_t'($signed(bus.in_0_i[2*gi]));
        assign a_hi   = prod_a_t'($signed(bus.in_0_i[2*gi+1]));
        assign b_lo   = prod_b_t'($signed(bus.in_1_i[2*gi]));
        assign b_hi   = prod_b_t'($signed(bus.in_1_i[2*gi+1]));
        assign prod_a = a_lo * a_hi;
        assign prod_b = b_lo * b_hi;
        assign pair_corr[gi] = RES_SIZE'(prod_a) + RES_SIZE'(prod_b);
    end

    always_comb begin
        corr_sum = '0;
        for (int j = 0; j < NUM_PAIRS; j++) begin
            corr_sum = corr_sum + pair_corr[j];
        end
    end

    assign tcnt_last       = (tcnt_reg == TCNT_W'(NUM_TILES - 1));
    assign final_in_flight = |dl_final_reg;
    // Only the final tile waits: it must find the result register empty when it lands.
    assign in_ready        = !tcnt_last || (!res_valid_reg && !final_in_flight);
    assign accept          = bus.in_valid_i && in_ready;
    assign aligned_valid   = dl_valid_reg[ARRAY_LATENCY-1];
    assign aligned_final   = dl_final_reg[ARRAY_LATENCY-1];

    // Upper array-word bits beyond RES_SIZE cannot affect a modulo-2^RES_SIZE result.
    assign arr_unused = ^bus.arr_out_i;

    always_comb begin
        term     = RES_SIZE'(bus.arr_out_i[0]) + RES_SIZE'(bus.arr_out_i[1])
                   - dl_corr_reg[ARRAY_LATENCY-1];
        acc_next = acc_reg + term;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dl_valid_reg <= '0;
            dl_final_reg <= '0;
            for (int k = 0; k < ARRAY_LATENCY; k++) begin
                dl_corr_reg[k] <= '0;
            end
        end else begin
            dl_valid_reg[0] <= accept;
            dl_final_reg[0] <= accept && tcnt_last;
            dl_corr_reg[0]  <= corr_sum;
            for (int k = 1; k < ARRAY_LATENCY; k++) begin
                dl_valid_reg[k] <= dl_valid_reg[k-1];
                dl_final_reg[k] <= dl_final_reg[k-1];
                dl_corr_reg[k]  <= dl_corr_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_reg      <= '0;
            acc_reg       <= '0;
            res_reg       <= '0;
            res_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                tcnt_reg <= tcnt_last ? '0 : tcnt_reg + 1'b1;
            end
            if (res_valid_reg && bus.res_ready_i) begin
                res_valid_reg <= 1'b0;
            end
            if (aligned_valid) begin
                if (aligned_final) begin
                    res_reg       <= acc_next;
                    res_valid_reg <= 1'b1;
                    acc_reg       <= '0;
                end else begin
                    acc_reg <= acc_next;
                end
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.res_valid_o = res_valid_reg;
    assign bus.res_o       = res_reg;
    assign bus.busy_o      = (tcnt_reg != '0) || (|dl_valid_reg) || res_valid_reg;
endmodule

// File: tb/tb_winograd_resolver.sv
// Self-checking bench for winograd_resolver: an emulated winograd array feeds
// the redundant output pair; a dot-product scoreboard predicts every result.
`timescale 1ns/1ps
module tb_winograd_resolver;
    localparam int IN0      = 4;
    localparam int IN1      = 8;
    localparam int AS       = 8;
    localparam int NT       = 4;
    localparam int AL       = 2;
    localparam int IN_MUL   = ((IN0 > IN1) ? IN0 : IN1) + 1;
    localparam int PP       = ((IN_MUL + 2) / 3) * AS;
    localparam int OUT_SIZE = 2 * IN_MUL + ($clog2(PP) - 1) * 2;
    localparam int RES_SIZE = IN0 + IN1 + $clog2(AS * NT);

    typedef int lanes_t [AS];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    winograd_resolver_if #(.IN_SIZE_0(IN0), .IN_SIZE_1(IN1), .ARRAY_SIZE(AS), .NUM_TILES(NT)) bus ();
    winograd_resolver_if #(.IN_SIZE_0(IN0), .IN_SIZE_1(IN1), .ARRAY_SIZE(AS), .NUM_TILES(1))  bus1 ();

    winograd_resolver #(.IN_SIZE_0(IN0), .IN_SIZE_1(IN1), .ARRAY_SIZE(AS),
                        .NUM_TILES(NT), .ARRAY_LATENCY(AL)) dut (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus)
    );
    winograd_resolver #(.IN_SIZE_0(IN0), .IN_SIZE_1(IN1), .ARRAY_SIZE(AS),
                        .NUM_TILES(1), .ARRAY_LATENCY(AL)) dut1 (
        .clk_i (clk), .rst_ni (rst_n), .bus (bus1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    // ---------------- winograd array emulation ----------------
    function automatic longint wino(input lanes_t a, input lanes_t b);
        longint s = 0;
        for (int j = 0; j < AS / 2; j++) begin
            s += longint'(a[2*j] + b[2*j+1]) * longint'(a[2*j+1] + b[2*j]);
        end
        return s;
    endfunction

    // Random split of the array value into two unsigned words summing to it mod 2^(OUT_SIZE+1).
    function automatic void split(input longint w, output logic [OUT_SIZE-1:0] w0,
                                  output logic [OUT_SIZE-1:0] w1);
        longint m    = longint'(1) << (OUT_SIZE + 1);
        longint top  = (longint'(1) << OUT_SIZE) - 1;
        longint r    = ((w % m) + m) % m;
        longint lo   = (r > top) ? r - top : 0;
        longint hi   = (r < top) ? r : top;
        longint pick = lo + (longint'($urandom) % (hi - lo + 1));
        w0 = OUT_SIZE'(pick);
        w1 = OUT_SIZE'(r - pick);
    endfunction

    function automatic lanes_t fill(input int v);
        lanes_t l;
        for (int i = 0; i < AS; i++) l[i] = v;
        return l;
    endfunction

    function automatic lanes_t rand_lanes(input int width);
        lanes_t l;
        for (int i = 0; i < AS; i++) l[i] = int'($urandom_range((1 << width) - 1)) - (1 << (width - 1));
        return l;
    endfunction

    longint wq0[$];
    longint wq1[$];

    task automatic drive_cycle(input bit sel, input bit v, input lanes_t a, input lanes_t b, input bit rdy);
        logic [OUT_SIZE-1:0] w0, w1;
        longint w;
        @(posedge clk);
        #1;
        if (!sel) begin
            bus.in_valid_i  = v;
            bus.res_ready_i = rdy;
            for (int i = 0; i < AS; i++) begin
                bus.in_0_i[i] = IN0'(a[i]);
                bus.in_1_i[i] = IN1'(b[i]);
            end
            wq0.push_back(wino(a, b));
            w = wq0.pop_front();
            split(w, w0, w1);
            bus.arr_out_i[0] = w0;
            bus.arr_out_i[1] = w1;
        end else begin
            bus1.in_valid_i  = v;
            bus1.res_ready_i = rdy;
            for (int i = 0; i < AS; i++) begin
                bus1.in_0_i[i] = IN0'(a[i]);
                bus1.in_1_i[i] = IN1'(b[i]);
            end
            wq1.push_back(wino(a, b));
            w = wq1.pop_front();
            split(w, w0, w1);
            bus1.arr_out_i[0] = w0;
            bus1.arr_out_i[1] = w1;
        end
    endtask

    task automatic idle(input bit sel);
        drive_cycle(sel, 1'b0, rand_lanes(IN0), rand_lanes(IN1), 1'b1);
    endtask

    // ---------------- scoreboard for the NUM_TILES=4 instance ----------------
    int     cyc = 0;
    int     m_tcnt = 0;
    longint m_acc = 0;
    bit     m_rv = 0;
    logic [RES_SIZE-1:0] m_res = '0;
    int     land_cyc[$];
    longint land_val[$];
    int     acc_cyc[$];
    int     last_final_cyc = 0;
    int     last_lat = -1;
    bit     prev_rv = 0;
    int     groups_done = 0;
    int     results_taken = 0;
    int     dut_stalls = 0;
    int     taken_q[$];

    function automatic longint bus_dot();
        longint s = 0;
        for (int i = 0; i < AS; i++) s += longint'($signed(bus.in_0_i[i])) * longint'($signed(bus.in_1_i[i]));
        return s;
    endfunction

    always @(negedge clk) begin
        bit exp_rdy;
        cyc++;
        if (!rst_n) begin
            check("rst_in_ready", bus.in_ready_o, 1);
            check("rst_res_valid", bus.res_valid_o, 0);
            check("rst_res", bus.res_o, 0);
            check("rst_busy", bus.busy_o, 0);
            m_tcnt = 0; m_acc = 0; m_rv = 0; prev_rv = 0;
            land_cyc.delete(); land_val.delete(); acc_cyc.delete();
        end else begin
            while (acc_cyc.size() > 0 && acc_cyc[0] < cyc - AL) void'(acc_cyc.pop_front());
            exp_rdy = (m_tcnt != NT - 1) || (!m_rv && land_cyc.size() == 0);
            check("in_ready", bus.in_ready_o, exp_rdy);
            check("res_valid", bus.res_valid_o, m_rv);
            check("busy", bus.busy_o, (m_tcnt != 0) || (acc_cyc.size() != 0) || m_rv);
            if (m_rv) check("res", bus.res_o, m_res);
            if (bus.res_valid_o && !prev_rv) last_lat = cyc - last_final_cyc;
            prev_rv = bus.res_valid_o;
            if (!bus.in_ready_o) dut_stalls++;
            if (m_rv && bus.res_ready_i) begin
                m_rv = 0;
                results_taken++;
                taken_q.push_back(int'($signed(bus.res_o)));
            end
            if (land_cyc.size() > 0 && land_cyc[0] == cyc) begin
                m_rv  = 1;
                m_res = RES_SIZE'(land_val.pop_front());
                void'(land_cyc.pop_front());
            end
            if (bus.in_valid_i && exp_rdy) begin
                acc_cyc.push_back(cyc);
                m_acc += bus_dot();
                if (m_tcnt == NT - 1) begin
                    land_cyc.push_back(cyc + AL);
                    land_val.push_back(m_acc);
                    m_acc = 0;
                    m_tcnt = 0;
                    groups_done++;
                    last_final_cyc = cyc;
                end else begin
                    m_tcnt++;
                end
            end
        end
    end

    // ---------------- checker for the NUM_TILES=1 instance ----------------
    bit phase1 = 0;
    int cyc1 = 0;
    bit m1_rv = 0;
    int m1_land = -1;
    int m1_last_acc = -100;
    int results1 = 0;

    always @(negedge clk) begin
        bit exp_rdy1;
        bit inflight1;
        cyc1++;
        if (phase1 && rst_n) begin
            inflight1 = (m1_last_acc >= cyc1 - AL);
            exp_rdy1  = !m1_rv && !inflight1;
            check("n1_in_ready", bus1.in_ready_o, exp_rdy1);
            check("n1_res_valid", bus1.res_valid_o, m1_rv);
            check("n1_busy", bus1.busy_o, m1_rv || inflight1);
            if (m1_rv && bus1.res_ready_i) begin
                check("n1_res", 64'($signed(bus1.res_o)), 64'(-8128));
                m1_rv = 0;
                results1++;
            end
            if (m1_land == cyc1) begin
                m1_rv = 1;
                m1_land = -1;
            end
            if (bus1.in_valid_i && exp_rdy1) begin
                m1_last_acc = cyc1;
                m1_land = cyc1 + AL;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send_tile(input int av, input int bv, input bit rdy);
        bit done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            drive_cycle(1'b0, 1'b1, fill(av), fill(bv), rdy);
            @(negedge clk);
            if (bus.in_ready_o) done = 1;
        end
        if (!done) check("send_tile_timeout", 0, 1);
    endtask

    task automatic wait_result(input string name, input int exp);
        for (int k = 0; k < 50 && taken_q.size() == 0; k++) idle(1'b0);
        if (taken_q.size() == 0) check({name, "_timeout"}, 0, 1);
        else check(name, 64'(taken_q.pop_front()), 64'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, g0, r0;
        rst_n = 1'b0;
        bus.in_valid_i = 1'b0;  bus.res_ready_i = 1'b1;  bus.in_0_i = '0;  bus.in_1_i = '0;  bus.arr_out_i = '0;
        bus1.in_valid_i = 1'b0; bus1.res_ready_i = 1'b1; bus1.in_0_i = '0; bus1.in_1_i = '0; bus1.arr_out_i = '0;
        for (int i = 0; i < AL; i++) begin
            wq0.push_back(0);
            wq1.push_back(0);
        end
        repeat (3) idle(1'b0);
        rst_n = 1'b1;
        idle(1'b0);

        // 1: 4 tiles a=7 b=127, valid held high, no stall, latency 3
        s0 = dut_stalls;
        taken_q.delete();
        for (int t = 0; t < 4; t++) send_tile(7, 127, 1'b1);
        wait_result("t1_res", 28448);
        check("t1_latency", 64'(last_lat), 64'(3));
        check("t1_no_stall", 64'(dut_stalls - s0), 64'(0));

        // 2: extreme negatives, mixed signs, zero
        for (int t = 0; t < 4; t++) send_tile(-8, -128, 1'b1);
        wait_result("t2_negneg", 32768);
        for (int t = 0; t < 4; t++) send_tile(7, -128, 1'b1);
        wait_result("t2_mixed", -28672);
        for (int t = 0; t < 4; t++) send_tile(0, 0, 1'b1);
        wait_result("t2_zero", 0);

        // 3: backpressure for 20 cycles with continuous valid
        taken_q.delete();
        s0 = dut_stalls;
        r0 = results_taken;
        for (int k = 0; k < 20; k++) drive_cycle(1'b0, 1'b1, fill(7), fill(127), 1'b0);
        check("t3_held_valid", bus.res_valid_o, 1);
        check("t3_held_res", 64'($signed(bus.res_o)), 64'(28448));
        check("t3_stalled", bus.in_ready_o, 0);
        check("t3_stall_seen", 64'(dut_stalls - s0 > 0), 64'(1));
        send_tile(7, 127, 1'b1);
        wait_result("t3_first", 28448);
        wait_result("t3_second", 28448);
        check("t3_count", 64'(results_taken - r0), 64'(2));

        // 4: reset mid-group
        send_tile(3, 5, 1'b1);
        send_tile(3, 5, 1'b1);
        idle(1'b0);
        rst_n = 1'b0;
        idle(1'b0);
        check("t4_busy_rst", bus.busy_o, 0);
        check("t4_res_rst", bus.res_o, 0);
        idle(1'b0);
        rst_n = 1'b1;
        taken_q.delete();
        for (int t = 0; t < 4; t++) send_tile(1, 1, 1'b1);
        wait_result("t4_after_rst", 32);

        // 6: random traffic, 500 groups
        g0 = groups_done;
        r0 = results_taken;
        for (int k = 0; k < 20000 && groups_done - g0 < 500; k++) begin
            drive_cycle(1'b0, ($urandom % 4) != 0, rand_lanes(IN0), rand_lanes(IN1), ($urandom % 3) != 0);
        end
        repeat (20) drive_cycle(1'b0, 1'b0, rand_lanes(IN0), rand_lanes(IN1), 1'b1);
        check("t6_groups", 64'(groups_done - g0), 64'(500));
        check("t6_results", 64'(results_taken - r0), 64'(groups_done - g0));

        // 5: NUM_TILES=1 instance, a=-8 b=127 continuous
        idle(1'b1);
        phase1 = 1;
        for (int k = 0; k < 40; k++) drive_cycle(1'b1, 1'b1, fill(-8), fill(127), (k % 4) != 3);
        repeat (10) drive_cycle(1'b1, 1'b0, fill(-8), fill(127), 1'b1);
        phase1 = 0;
        check("t5_result_count_min", 64'(results1 >= 5), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/winograd_resolver.md
Name: winograd_resolver

Overview:
Receive-side companion of the winograd inner-product array. It consumes the array's two-word redundant output pair and removes the Winograd correction terms (sum a[2j]*a[2j+1] + sum b[2j]*b[2j+1]), which it computes from the same operand tile. It accumulates NUM_TILES tiles into one exact signed dot product and delivers it on a valid/ready result port. It also gates tile issue so that no result is ever dropped.

Parameters:
IN_SIZE_0, 4, signed width of operand A lanes (in_0).
IN_SIZE_1, 8, signed width of operand B lanes (in_1).
ARRAY_SIZE, 8, lanes per tile; must be even.
NUM_TILES, 4, tiles accumulated per result; must be at least 1.
ARRAY_LATENCY, 2, cycles from operand cycle to the array output cycle; must be at least 1.
OUT_SIZE (localparam), width of each array output word. Computed as IN_MUL=max(IN_SIZE_0,IN_SIZE_1)+1, PP=((IN_MUL+2)/3)*ARRAY_SIZE, then 2*IN_MUL+($clog2(PP)-1)*2.
RES_SIZE (localparam), IN_SIZE_0+IN_SIZE_1+$clog2(ARRAY_SIZE*NUM_TILES). Elaboration error if RES_SIZE > OUT_SIZE+1.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
in_valid_i  in  1  operand tile present on in_0_i/in_1_i (the same wires also drive the array).
in_ready_o  out  1  tile accepted at this edge when in_valid_i && in_ready_o.
in_0_i  in  ARRAY_SIZE x IN_SIZE_0  operand A lanes, signed.
in_1_i  in  ARRAY_SIZE x IN_SIZE_1  operand B lanes, signed.
arr_out_i  in  2 x OUT_SIZE  array output pair; the array result equals the sum of both words modulo 2^(OUT_SIZE+1).
res_valid_o  out  1  result available.
res_ready_i  in  1  downstream accepts the result.
res_o  out  RES_SIZE  signed dot product of NUM_TILES tiles.
busy_o  out  1  a tile is in flight, a partial group is open, or a result is pending.

Behaviour:
- Reset (async, rst_ni=0): res_valid_o=0, res_o=0, busy_o=0, tile counter=0, accumulator=0, all delay-line valid bits=0. in_ready_o=1 during reset and immediately after it.
- Tile counter tcnt counts 0..NUM_TILES-1. It advances on each accept and wraps to 0 after NUM_TILES-1. A tile accepted with tcnt==NUM_TILES-1 is tagged final.
- Correction for a tile accepted in cycle c: corr = sum over j of (a[2j]*a[2j+1] + b[2j]*b[2j+1]).
  - Computed combinationally in cycle c, sign-extended, modulo 2^RES_SIZE.
  - Registered with {valid, final} at the end of cycle c, then carried through ARRAY_LATENCY-1 further stages so it aligns with cycle c+ARRAY_LATENCY.
- Cycle c+ARRAY_LATENCY (aligned valid=1):
  - term = trunc_RES(arr_out_i[0]) + trunc_RES(arr_out_i[1]) - corr. All arithmetic is two's complement modulo 2^RES_SIZE.
  - Non-final tile: acc <= acc + term.
  - Final tile: res_o <= acc + term, res_valid_o <= 1, acc <= 0 in the same edge.
- arr_out_i is ignored in cycles whose aligned valid bit is 0. Operands present while in_ready_o=0, or with in_valid_i=0, have no effect.
- Issue gating:
  - in_ready_o = !(tcnt==NUM_TILES-1) || (!res_valid_o && !final_in_flight).
  - final_in_flight is the OR of the final tags in the delay line.
  - Non-final tiles are never stalled.
  - Consequence: the result register is always empty when a final tile lands. No overflow and no drop are possible, so no error output exists.
- Result handshake:
  - res_valid_o && res_ready_i at an edge clears res_valid_o.
  - res_o holds its value and res_valid_o stays high while res_ready_i=0.
  - res_o keeps its last value after it is taken.
- Back-to-back operation: a final-tile stall releases in the cycle after the result is taken. Tiles of the next group accumulate while a result is pending.
- Latency: res_valid_o rises at the end of cycle c+ARRAY_LATENCY, where c is the final tile's accept cycle. It is first visible in cycle c+ARRAY_LATENCY+1 (3 cycles by default).
- NUM_TILES=1: every tile is final; throughput is one result per ARRAY_LATENCY+1 cycles or slower.
- busy_o = (tcnt!=0) || any delay-line valid || res_valid_o.
- Reset mid-operation: all in-flight tiles and partial sums are discarded. The first group after reset starts at tcnt=0 and is exact.

Test Plan:
1. Defaults; real winograd array driven with the same operands; 4 tiles, all a=7, b=127, in_valid_i held high -> in_ready_o stays 1; res_o=28448 (4*8*7*127), res_valid_o rises 3 cycles after the 4th accept.
2. 4 tiles, all a=-8, b=-128 -> res_o=32768. Then 4 tiles, a=7, b=-128 -> res_o=-28672. Then all zero -> res_o=0.
3. Backpressure: res_ready_i=0 for 20 cycles with continuous in_valid_i.
   - res_o stays 28448 and res_valid_o stays 1.
   - in_ready_o drops at the 4th tile of group 2.
   - After res_ready_i=1, group 2's result is exactly one handshake later; no result is lost.
4. Reset mid-group: 2 tiles accepted, then rst_ni=0 for 2 cycles -> res_valid_o=0, res_o=0, busy_o=0. A fresh 4-tile group a=1, b=1 then gives res_o=32.
5. NUM_TILES=1, ARRAY_LATENCY=2, a=-8, b=127 per tile, continuous valid -> each res_o=-8128; in_ready_o low until the prior result is taken.
6. 500 random groups with random in_valid_i gaps and random res_ready_i; the bench compares res_o to a signed reference dot product of the tiles in order -> zero mismatches, and the result count equals the group count.
